// File: rtl/led_status_pkg.sv
// Shared mode encoding, counter widths and the per-mode blink pattern for the status LED.
package led_status_pkg;

    localparam int PHASE_W = 3;
    localparam int HOLD_W  = 8;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_LINK = 2'b01,
        MODE_ACT  = 2'b10,
        MODE_ERR  = 2'b11
    } mode_e;

    // Phase is the value the phase counter takes on the same tick edge.
    function automatic logic pattern_led(input mode_e m, input logic [PHASE_W-1:0] phase);
        logic on;
        on = 1'b0;
        case (m)
            MODE_IDLE: on = (phase == '0);
            MODE_LINK: on = 1'b1;
            MODE_ACT:  on = phase[1];
            MODE_ERR:  on = phase[0];
            default:   on = 1'b0;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/led_status_ctrl_tick_gen.sv
// Free-running prescaler; tick_int marks the last enabled cycle before the counter wraps.
module tick_gen #(
    parameter int TICK_WIDTH = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick_int
);

    logic [TICK_WIDTH-1:0] cnt_q;
    logic [TICK_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + TICK_WIDTH'(1);
        end
    end

    assign tick_int = en && (cnt_q == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_status_ctrl.sv
// Status LED scheduler: arbitrates error, activity, link and idle indicators once per
// prescaler tick and drives the winning source's blink pattern onto a single LED.
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int TICK_WIDTH = 24,
    parameter int ACT_HOLD   = 4,
    parameter int STICKY_ERR = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       err,
    input  logic       err_clr,
    input  logic       link_up,
    input  logic       act_pulse,
    output logic       led,
    output logic [1:0] mode,
    output logic       tick
);

    logic               tick_int;
    logic               err_q,   err_d;
    logic [HOLD_W-1:0]  hold_q,  hold_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    mode_e              mode_q,  mode_d;
    logic               led_q,   led_d;
    logic               tick_q;

    tick_gen #(
        .TICK_WIDTH (TICK_WIDTH)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .tick_int (tick_int)
    );

    // Arbitration reads the registered hold/err_q, so a same-cycle act_pulse or err
    // only influences the tick edge after the one it lands on.
    always_comb begin
        err_d   = err_q;
        hold_d  = hold_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        led_d   = led_q;

        if (STICKY_ERR != 0) begin
            if (err) begin
                err_d = 1'b1;
            end else if (err_clr) begin
                err_d = 1'b0;
            end
        end else begin
            err_d = err;
        end

        if (act_pulse) begin
            hold_d = HOLD_W'(ACT_HOLD);
        end else if (tick_int && (hold_q != '0)) begin
            hold_d = hold_q - HOLD_W'(1);
        end

        if (tick_int) begin
            phase_d = phase_q + PHASE_W'(1);
            if (err_q) begin
                mode_d = MODE_ERR;
            end else if (hold_q != '0) begin
                mode_d = MODE_ACT;
            end else if (link_up) begin
                mode_d = MODE_LINK;
            end else begin
                mode_d = MODE_IDLE;
            end
            led_d = pattern_led(mode_d, phase_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            hold_q  <= '0;
            phase_q <= '0;
            mode_q  <= MODE_IDLE;
            led_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            err_q   <= err_d;
            hold_q  <= hold_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
            tick_q  <= tick_int;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Randomised and directed bench for led_status_ctrl against a tick-counting reference model.
module tb_led_status_ctrl;

    localparam int TW     = 2;
    localparam int AH     = 2;
    localparam int SE     = 1;
    localparam int PERIOD = 1 << TW;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       err = 1'b0;
    logic       err_clr = 1'b0;
    logic       link_up = 1'b0;
    logic       act_pulse = 1'b0;
    logic       led;
    logic [1:0] mode;
    logic       tick;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: counts enabled cycles and ticks since reset.
    int mCnt = 0;
    int mTicks = 0;
    int mHold = 0;
    bit mErr = 0;
    int mMode = 0;
    bit mLed = 0;
    bit mTick = 0;

    led_status_ctrl #(
        .TICK_WIDTH (TW),
        .ACT_HOLD   (AH),
        .STICKY_ERR (SE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .err       (err),
        .err_clr   (err_clr),
        .link_up   (link_up),
        .act_pulse (act_pulse),
        .led       (led),
        .mode      (mode),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic modelEdge();
        bit tickNow;
        int src;
        int ph;
        if (!rst_n) begin
            mCnt = 0; mTicks = 0; mHold = 0; mErr = 0;
            mMode = 0; mLed = 0; mTick = 0;
        end else begin
            tickNow = en && ((mCnt % PERIOD) == PERIOD - 1);
            if (tickNow) begin
                if (mErr) src = 3;
                else if (mHold > 0) src = 2;
                else if (link_up) src = 1;
                else src = 0;
                mTicks = mTicks + 1;
                ph = mTicks % 8;
                mMode = src;
                case (src)
                    0: mLed = (ph == 0);
                    1: mLed = 1'b1;
                    2: mLed = ((ph / 2) % 2) == 1;
                    default: mLed = (ph % 2) == 1;
                endcase
            end
            if (act_pulse) mHold = AH;
            else if (tickNow && mHold > 0) mHold = mHold - 1;
            if (SE != 0) mErr = err || (mErr && !err_clr);
            else mErr = err;
            if (en) mCnt = mCnt + 1;
            mTick = tickNow;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic test_reset();
        int cyc;
        int ticksSeen;
        rst_n = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) stepCycle();
        nCompared++;
        if ({led, mode, tick} !== 4'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got led=%b mode=%b tick=%b, want all 0", led, mode, tick);
        end
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            stepCycle();
            cyc = i;
            if (tick === 1'b1) break;
        end
        nCompared++;
        if (cyc != 4 || tick !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_first_tick: tick after %0d cycles (tick=%b), want 4", cyc, tick);
        end
        nCompared++;
        if (led !== 1'b0 || mode !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL reset_tick1_led: got led=%b mode=%b, want led=0 mode=00", led, mode);
        end
        ticksSeen = 1;
        for (int i = 0; i < 60 && ticksSeen < 8; i++) begin
            stepCycle();
            if (tick === 1'b1) ticksSeen++;
            nCompared++;
            if ({led, mode, tick} !== {mLed, 2'(mMode), mTick}) begin
                nMismatched++;
                $display("[TB] FAIL idle_pattern: got %b%b%b want %b%b%b", led, mode, tick, mLed, 2'(mMode), mTick);
            end
        end
        nCompared++;
        if (ticksSeen != 8 || led !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL idle_heartbeat: ticks=%0d led=%b, want ticks=8 led=1", ticksSeen, led);
        end
    endtask

    task automatic test_link();
        link_up = 1'b1;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            stepCycle();
            nCompared++;
            if ({led, mode, tick} !== {mLed, 2'(mMode), mTick}) begin
                nMismatched++;
                $display("[TB] FAIL link_cycle: got %b%b%b want %b%b%b", led, mode, tick, mLed, 2'(mMode), mTick);
            end
        end
        nCompared++;
        if (mode !== 2'b01 || led !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL link_steady: got mode=%b led=%b, want 01/1", mode, led);
        end
    endtask

    task automatic test_act();
        int actTicks;
        actTicks = 0;
        act_pulse = 1'b1;
        stepCycle();
        act_pulse = 1'b0;
        for (int i = 0; i < 5 * PERIOD; i++) begin
            stepCycle();
            if (tick === 1'b1 && mode === 2'b10) actTicks++;
            nCompared++;
            if ({led, mode, tick} !== {mLed, 2'(mMode), mTick}) begin
                nMismatched++;
                $display("[TB] FAIL act_cycle: got %b%b%b want %b%b%b", led, mode, tick, mLed, 2'(mMode), mTick);
            end
        end
        nCompared++;
        if (actTicks != AH || mode !== 2'b01) begin
            nMismatched++;
            $display("[TB] FAIL act_hold: act ticks=%0d final mode=%b, want %0d and 01", actTicks, mode, AH);
        end
    endtask

    task automatic test_err();
        bit prevLed;
        err = 1'b1;
        stepCycle();
        err = 1'b0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            prevLed = led;
            stepCycle();
            nCompared++;
            if ({led, mode, tick} !== {mLed, 2'(mMode), mTick}) begin
                nMismatched++;
                $display("[TB] FAIL err_cycle: got %b%b%b want %b%b%b", led, mode, tick, mLed, 2'(mMode), mTick);
            end
            if (tick === 1'b1 && i >= PERIOD) begin
                nCompared++;
                if (led === prevLed) begin
                    nMismatched++;
                    $display("[TB] FAIL err_toggle: led stayed %b across tick", led);
                end
            end
        end
        nCompared++;
        if (mode !== 2'b11) begin
            nMismatched++;
            $display("[TB] FAIL err_sticky: got mode=%b, want 11", mode);
        end
        err_clr = 1'b1;
        stepCycle();
        err_clr = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) stepCycle();
        nCompared++;
        if (mode !== 2'b01 || mode !== 2'(mMode)) begin
            nMismatched++;
            $display("[TB] FAIL err_clear: got mode=%b, want 01 (model %0d)", mode, mMode);
        end
        err = 1'b1; err_clr = 1'b1;
        stepCycle();
        err = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) stepCycle();
        nCompared++;
        if (mode !== 2'b11 || led !== mLed) begin
            nMismatched++;
            $display("[TB] FAIL err_set_wins: got mode=%b led=%b, want 11 led=%b", mode, led, mLed);
        end
        err_clr = 1'b1;
        stepCycle();
        err_clr = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) stepCycle();
    endtask

    task automatic test_enable();
        logic       heldLed;
        logic [1:0] heldMode;
        bit         sawTick;
        for (int i = 0; i < 3 * PERIOD && tick !== 1'b1; i++) stepCycle();
        stepCycle();
        heldLed = led; heldMode = mode;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            nCompared++;
            if (tick !== 1'b0 || led !== heldLed || mode !== heldMode) begin
                nMismatched++;
                $display("[TB] FAIL en_freeze: got led=%b mode=%b tick=%b, want %b %b 0", led, mode, tick, heldLed, heldMode);
            end
        end
        en = 1'b1;
        sawTick = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            stepCycle();
            if (tick === 1'b1) sawTick = 1;
            nCompared++;
            if ({led, mode, tick} !== {mLed, 2'(mMode), mTick}) begin
                nMismatched++;
                $display("[TB] FAIL en_resume: got %b%b%b want %b%b%b", led, mode, tick, mLed, 2'(mMode), mTick);
            end
        end
        nCompared++;
        if (!sawTick) begin
            nMismatched++;
            $display("[TB] FAIL en_resume_tick: got no tick, want tick within %0d cycles", 3 * PERIOD);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        link_up = 1'b1;
        act_pulse = 1'b1;
        stepCycle();
        act_pulse = 1'b0;
        for (int i = 0; i < 3 * PERIOD && mode !== 2'b10; i++) stepCycle();
        nCompared++;
        if (mode !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL midrst_setup: got mode=%b, want 10", mode);
        end
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        nCompared++;
        if ({led, mode, tick} !== 4'b0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_clear: got led=%b mode=%b tick=%b, want all 0", led, mode, tick);
        end
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            stepCycle();
            cyc = i;
            if (tick === 1'b1) break;
        end
        nCompared++;
        if (cyc != 4 || mode !== 2'b01 || mode !== 2'(mMode)) begin
            nMismatched++;
            $display("[TB] FAIL midrst_restart: tick after %0d cycles mode=%b, want 4 cycles mode=01", cyc, mode);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            act_pulse = ($urandom_range(0, 15) == 0);
            err       = ($urandom_range(0, 31) == 0);
            err_clr   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 19) == 0) link_up = ~link_up;
            rst_n     = ($urandom_range(0, 199) != 0);
            stepCycle();
            nCompared++;
            if ({led, mode, tick} !== {mLed, 2'(mMode), mTick}) begin
                nMismatched++;
                $display("[TB] FAIL random_cycle%0d: got %b%b%b want %b%b%b", i, led, mode, tick, mLed, 2'(mMode), mTick);
            end
        end
        rst_n = 1'b1; en = 1'b1; act_pulse = 1'b0; err = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_link();
        test_act();
        test_err();
        test_enable();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
